// File: rtl/cpu_exc_pkg.sv
// -----------------------------------------------------------------------------
// cpu_exc_pkg
// Shared types and constants for the privileged exception controller:
//   exc_state_t  - controller FSM states
//   exc_cause_t  - trap cause encoding as exposed on the cause output / rm regs
//   OPC_*        - decoded opcodes that are privileged
//   HANDLER_PC_DEFAULT - default trap handler entry address
// -----------------------------------------------------------------------------
package cpu_exc_pkg;

  typedef enum logic [2:0] {
    USER   = 3'd0,
    TRAP   = 3'd1,
    SUPER  = 3'd2,
    RETURN = 3'd3,
    HALT   = 3'd4
  } exc_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ITLB = 2'd1,
    DTLB = 2'd2,
    PRIV = 2'd3
  } exc_cause_t;

  localparam logic [6:0]  OPC_TLBWRITE       = 7'h32;
  localparam logic [6:0]  OPC_IRET           = 7'h33;
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h2000;

  // Opcodes that may only execute in supervisor mode.
  function automatic logic is_priv_op(input logic [6:0] opc);
    return (opc == OPC_TLBWRITE) || (opc == OPC_IRET);
  endfunction

endpackage

// File: rtl/cpu_exc_prio.sv
// -----------------------------------------------------------------------------
// cpu_exc_prio
// Combinational priority encoder for user-mode exceptions. The memory-stage
// miss belongs to the oldest instruction, so it wins over a fetch miss, which
// in turn wins over a privilege violation in decode.
// Ports:
//   itlb_exc_i / itlb_exc_pc_i              fetch TLB miss and its address
//   dtlb_exc_i / dtlb_exc_pc_i / _addr_i    memory TLB miss, PC, data address
//   dec_valid_i / dec_opcode_i / dec_pc_i   decoded instruction
//   exc_valid_o                             some exception is pending
//   cause_o                                 winning cause
//   fault_pc_o / fault_addr_o               values to latch into rm0 / rm1
// -----------------------------------------------------------------------------
module cpu_exc_prio
  import cpu_exc_pkg::*;
#(
  parameter int unsigned VADDR_W = 32
) (
  input  logic               itlb_exc_i,
  input  logic [VADDR_W-1:0] itlb_exc_pc_i,
  input  logic               dtlb_exc_i,
  input  logic [VADDR_W-1:0] dtlb_exc_pc_i,
  input  logic [VADDR_W-1:0] dtlb_exc_addr_i,
  input  logic               dec_valid_i,
  input  logic [6:0]         dec_opcode_i,
  input  logic [VADDR_W-1:0] dec_pc_i,
  output logic               exc_valid_o,
  output exc_cause_t         cause_o,
  output logic [VADDR_W-1:0] fault_pc_o,
  output logic [VADDR_W-1:0] fault_addr_o
);

  always_comb begin
    exc_valid_o  = 1'b0;
    cause_o      = NONE;
    fault_pc_o   = '0;
    fault_addr_o = '0;
    if (dtlb_exc_i) begin
      exc_valid_o  = 1'b1;
      cause_o      = DTLB;
      fault_pc_o   = dtlb_exc_pc_i;
      fault_addr_o = dtlb_exc_addr_i;
    end else if (itlb_exc_i) begin
      exc_valid_o  = 1'b1;
      cause_o      = ITLB;
      fault_pc_o   = itlb_exc_pc_i;
      fault_addr_o = itlb_exc_pc_i;
    end else if (dec_valid_i && is_priv_op(dec_opcode_i)) begin
      exc_valid_o  = 1'b1;
      cause_o      = PRIV;
      fault_pc_o   = dec_pc_i;
      fault_addr_o = dec_pc_i;
    end
  end

endmodule

// File: rtl/cpu_exception_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_exception_ctrl
// Privileged-control sequencer: takes TLB-miss and privilege traps in user
// mode, runs TLBWRITE / IRET in supervisor mode, owns rm0/rm1/rm4, and
// flushes/redirects fetch. A TLB miss while already in supervisor mode is a
// double fault and halts the core until reset.
// Ports:
//   clk, reset (async, active-high)
//   dec_*            decoded instruction and TLBWRITE operands
//   itlb_exc*, dtlb_exc*  TLB miss reports from fetch / memory stage
//   flush, redirect_valid, redirect_pc   fetch control
//   rm0, rm1, rm4, cause                 privileged registers
//   tlb_write_*, itlb_write              TLB write port (one-cycle strobe)
//   halted                               sticky double-fault indication
// Optional (macro CPU_EXC_CTRL_PERF_EN):
//   trap_count  saturating count of TRAP entries
//   dfault_seen copy of halted for the perf bus
// -----------------------------------------------------------------------------
module cpu_exception_ctrl
  import cpu_exc_pkg::*;
#(
  parameter int unsigned        VADDR_W    = 32,
  parameter logic [VADDR_W-1:0] HANDLER_PC = VADDR_W'(HANDLER_PC_DEFAULT),
  parameter int unsigned        PADDR_W    = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  input  logic [6:0]         dec_opcode,
  input  logic [VADDR_W-1:0] dec_pc,
  input  logic [VADDR_W-1:0] dec_src1_val,
  input  logic [PADDR_W-1:0] dec_src2_val,
  input  logic               dec_itlb_sel,
  input  logic               itlb_exc,
  input  logic [VADDR_W-1:0] itlb_exc_pc,
  input  logic               dtlb_exc,
  input  logic [VADDR_W-1:0] dtlb_exc_pc,
  input  logic [VADDR_W-1:0] dtlb_exc_addr,
  output logic               flush,
  output logic               redirect_valid,
  output logic [VADDR_W-1:0] redirect_pc,
  output logic [VADDR_W-1:0] rm0,
  output logic [VADDR_W-1:0] rm1,
  output logic               rm4,
  output logic [1:0]         cause,
  output logic               tlb_write_valid,
  output logic [VADDR_W-1:0] tlb_write_vaddr,
  output logic [PADDR_W-1:0] tlb_write_paddr,
  output logic               itlb_write,
`ifdef CPU_EXC_CTRL_PERF_EN
  output logic [15:0]        trap_count,
  output logic               dfault_seen,
`endif
  output logic               halted
);

  exc_state_t         state_q, state_d;
  logic [VADDR_W-1:0] rm0_q, rm0_d, rm1_q, rm1_d;
  logic               rm4_q, rm4_d;
  exc_cause_t         cause_q, cause_d;
  logic               tlbw_valid_q, tlbw_valid_d;
  logic [VADDR_W-1:0] tlbw_vaddr_q, tlbw_vaddr_d;
  logic [PADDR_W-1:0] tlbw_paddr_q, tlbw_paddr_d;
  logic               tlbw_itlb_q, tlbw_itlb_d;

  logic               exc_valid;
  exc_cause_t         exc_cause;
  logic [VADDR_W-1:0] fault_pc, fault_addr;

  cpu_exc_prio #(.VADDR_W(VADDR_W)) u_prio (
    .itlb_exc_i     (itlb_exc),
    .itlb_exc_pc_i  (itlb_exc_pc),
    .dtlb_exc_i     (dtlb_exc),
    .dtlb_exc_pc_i  (dtlb_exc_pc),
    .dtlb_exc_addr_i(dtlb_exc_addr),
    .dec_valid_i    (dec_valid),
    .dec_opcode_i   (dec_opcode),
    .dec_pc_i       (dec_pc),
    .exc_valid_o    (exc_valid),
    .cause_o        (exc_cause),
    .fault_pc_o     (fault_pc),
    .fault_addr_o   (fault_addr)
  );

  always_comb begin
    state_d        = state_q;
    rm0_d          = rm0_q;
    rm1_d          = rm1_q;
    rm4_d          = rm4_q;
    cause_d        = cause_q;
    tlbw_valid_d   = 1'b0;           // strobe lasts exactly one cycle
    tlbw_vaddr_d   = tlbw_vaddr_q;
    tlbw_paddr_d   = tlbw_paddr_q;
    tlbw_itlb_d    = tlbw_itlb_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      USER: begin
        if (exc_valid) begin
          state_d = TRAP;
          rm0_d   = fault_pc;
          rm1_d   = fault_addr;
          cause_d = exc_cause;
        end
      end
      TRAP: begin
        // Exceptions seen here belong to instructions being flushed anyway.
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_PC;
        rm4_d          = 1'b1;
        state_d        = SUPER;
      end
      SUPER: begin
        if (itlb_exc || dtlb_exc) begin
          state_d = HALT;            // double fault outranks any decode action
        end else if (dec_valid && dec_opcode == OPC_TLBWRITE) begin
          tlbw_valid_d = 1'b1;
          tlbw_vaddr_d = dec_src1_val;
          tlbw_paddr_d = dec_src2_val;
          tlbw_itlb_d  = dec_itlb_sel;
        end else if (dec_valid && dec_opcode == OPC_IRET) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = rm0_q;
        rm4_d          = 1'b0;
        cause_d        = NONE;
        state_d        = USER;
      end
      HALT: begin
        flush = 1'b1;
      end
      default: state_d = USER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= USER;
      rm0_q        <= '0;
      rm1_q        <= '0;
      rm4_q        <= 1'b0;
      cause_q      <= NONE;
      tlbw_valid_q <= 1'b0;
      tlbw_vaddr_q <= '0;
      tlbw_paddr_q <= '0;
      tlbw_itlb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rm0_q        <= rm0_d;
      rm1_q        <= rm1_d;
      rm4_q        <= rm4_d;
      cause_q      <= cause_d;
      tlbw_valid_q <= tlbw_valid_d;
      tlbw_vaddr_q <= tlbw_vaddr_d;
      tlbw_paddr_q <= tlbw_paddr_d;
      tlbw_itlb_q  <= tlbw_itlb_d;
    end
  end

  assign rm0             = rm0_q;
  assign rm1             = rm1_q;
  assign rm4             = rm4_q;
  assign cause           = cause_q;
  assign tlb_write_valid = tlbw_valid_q;
  assign tlb_write_vaddr = tlbw_vaddr_q;
  assign tlb_write_paddr = tlbw_paddr_q;
  assign itlb_write      = tlbw_itlb_q;
  assign halted          = (state_q == HALT);

`ifdef CPU_EXC_CTRL_PERF_EN
  logic [15:0] trap_count_q, trap_count_d;

  always_comb begin
    trap_count_d = trap_count_q;
    if (state_q == USER && state_d == TRAP && trap_count_q != 16'hFFFF)
      trap_count_d = trap_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_count_q <= '0;
    else       trap_count_q <= trap_count_d;
  end

  assign trap_count  = trap_count_q;
  assign dfault_seen = halted;
`endif

endmodule

// File: doc/cpu_exception_ctrl.md
Name: cpu_exception_ctrl

Overview:
- Sequences privileged control for the core: TLB-miss traps, privilege violations, TLBWRITE and IRET.
- Owns the privileged registers rm0 (saved PC), rm1 (fault address) and rm4 (supervisor flag) that feed the decode interface.
- Flushes and redirects fetch, and drives the TLB write port (tlb_write, itlb_write).
- Sits beside the decode stage; consumes fetch/memory TLB exceptions and decoded opcodes.

Parameters:
VADDR_W, 32, virtual address width (matches VIRTUAL_ADDR_WIDTH)
HANDLER_PC, 'h2000, trap handler entry address
PADDR_W, 20, physical address width written into TLB entries

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
dec_valid  in  1  decode holds a valid instruction
dec_opcode  in  7  decoded opcode (ADD..IRET encoding, TLBWRITE='h32, IRET='h33)
dec_pc  in  VADDR_W  PC of decoded instruction
dec_src1_val  in  VADDR_W  TLBWRITE virtual address operand
dec_src2_val  in  PADDR_W  TLBWRITE physical address operand
dec_itlb_sel  in  1  TLBWRITE target: 1=ITLB, 0=DTLB
itlb_exc  in  1  fetch TLB miss
itlb_exc_pc  in  VADDR_W  faulting fetch address
dtlb_exc  in  1  memory-stage TLB miss
dtlb_exc_pc  in  VADDR_W  PC of faulting memory instruction
dtlb_exc_addr  in  VADDR_W  faulting data address
flush  out  1  kill all younger in-flight instructions
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  VADDR_W  new fetch PC
rm0  out  VADDR_W  saved return PC
rm1  out  VADDR_W  fault address
rm4  out  1  supervisor mode
cause  out  2  0=none, 1=ITLB miss, 2=DTLB miss, 3=privilege
tlb_write_valid  out  1  one-cycle TLB write strobe
tlb_write_vaddr  out  VADDR_W  entry virtual address
tlb_write_paddr  out  PADDR_W  entry physical address
itlb_write  out  1  strobe targets ITLB (valid only with tlb_write_valid)
halted  out  1  sticky double-fault halt

Behaviour:
- Reset (async): state USER; all outputs 0 (rm0, rm1, rm4, cause, flush, redirect, tlb strobes, halted).
- States: USER, TRAP, SUPER, RETURN, HALT.
- USER:
  - dtlb_exc → TRAP; latch rm0=dtlb_exc_pc, rm1=dtlb_exc_addr, cause=2.
  - Else itlb_exc → TRAP; latch rm0=rm1=itlb_exc_pc, cause=1.
  - Else dec_valid with TLBWRITE or IRET → TRAP; latch rm0=rm1=dec_pc, cause=3.
  - Priority: dtlb > itlb > privilege (oldest instruction first).
- TRAP (1 cycle): flush=1, redirect_valid=1, redirect_pc=HANDLER_PC, rm4←1 at exit → SUPER.
- SUPER:
  - dec_valid & TLBWRITE: next cycle tlb_write_valid=1 for exactly 1 cycle; vaddr/paddr/itlb_write registered from dec_*; stay SUPER.
  - dec_valid & IRET → RETURN.
  - Any itlb_exc/dtlb_exc in SUPER → HALT (double fault); takes priority over IRET/TLBWRITE in the same cycle.
- RETURN (1 cycle): flush=1, redirect_valid=1, redirect_pc=rm0; rm4←0, cause←0 at exit → USER.
- HALT: flush=1 held, halted=1, no strobes; exits only by reset.
- flush and redirect_valid are single-cycle pulses except in HALT; latency exception→redirect = 1 cycle.
- rm0/rm1 change only on entry to TRAP; unaffected by TLBWRITE.
- An exception arriving in TRAP or RETURN is ignored; the instruction is flushed anyway.
- Reset mid-TRAP/RETURN: immediate return to USER, pending pulses dropped.

Optional Feature:
- Macro CPU_EXC_CTRL_PERF_EN.
- When defined: extra output trap_count[15:0] counts TRAP entries, saturating at 'hFFFF, cleared by reset; a second output dfault_seen mirrors halted for the perf bus.
- When undefined: both ports and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_exc_pkg holds:
  - exc_state_t enum (USER, TRAP, SUPER, RETURN, HALT);
  - exc_cause_t (NONE, ITLB, DTLB, PRIV);
  - opcode constants OPC_TLBWRITE='h32, OPC_IRET='h33;
  - HANDLER_PC default.
- Natural sub-module: cpu_exc_prio, a combinational priority encoder producing cause and fault PC/address from the exception inputs.

Test Plan:
- USER, dtlb_exc with pc='h100, addr='h5000 → next cycle flush=1, redirect_pc='h2000; then rm0='h100, rm1='h5000, cause=2, rm4=1.
- USER, dtlb_exc and itlb_exc same cycle (itlb pc='h200) → cause=2, rm0 = dtlb pc.
- USER decodes TLBWRITE at pc='h300 → cause=3, rm0='h300, no tlb_write_valid.
- SUPER decodes TLBWRITE vaddr='h4000, paddr='h123, itlb_sel=1 → tlb_write_valid for exactly one cycle with those values and itlb_write=1.
- SUPER decodes IRET with rm0='h100 → flush + redirect_pc='h100; rm4=0 and cause=0 next cycle.
- SUPER, itlb_exc → halted=1, flush held; reset asserted mid-HALT → all outputs 0, state USER.
